// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: owns the PC, selects the next fetch address and
// registers the fetched word into the IF/ID pipeline register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic [15:0] imm16,
  output logic        misalign
);

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [1:0] SRC_JR     = 2'b11;

  logic [31:0] pc_plus4;
  logic [31:0] raw_target;
  logic        redirect;

  assign pc_plus4  = pc + 32'd4;
  assign redirect  = (pc_src != SRC_SEQ);
  assign imem_addr = pc;
  assign imm16     = ifid_instr[15:0];

  // Jump region comes from the PC+4 of the J/JAL instruction now sitting in decode.
  always_comb begin
    raw_target = pc_plus4;
    case (pc_src)
      SRC_BRANCH: raw_target = branch_target;
      SRC_JUMP:   raw_target = {ifid_pc4[31:28], jump_index, 2'b00};
      SRC_JR:     raw_target = jr_target;
      default:    raw_target = pc_plus4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      misalign   <= 1'b0;
      ifid_instr <= NOP_WORD;
      ifid_pc4   <= 32'd0;
      ifid_valid <= 1'b0;
    end else begin
      // A redirect must not be lost to a stall, so it takes precedence.
      if (redirect)
        pc <= {raw_target[31:2], 2'b00};
      else if (!stall)
        pc <= pc_plus4;

      misalign <= redirect && (raw_target[1:0] != 2'b00);

      if (flush) begin
        ifid_instr <= NOP_WORD;
        ifid_pc4   <= 32'd0;
        ifid_valid <= 1'b0;
      end else if (!stall) begin
        ifid_instr <= imem_rdata;
        ifid_pc4   <= pc_plus4;
        ifid_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage; instruction memory returns addr ^ 32'hA5A5_0000.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [1:0]  pc_src;
  logic [31:0] branch_target, jr_target, imem_addr, imem_rdata, pc;
  logic [25:0] jump_index;
  logic [31:0] ifid_instr, ifid_pc4;
  logic        ifid_valid, misalign;
  logic [15:0] imm16;
  int          errors = 0;
  int          checks = 0;

  if_stage #(.RESET_PC(32'h0), .NOP_WORD(32'h0)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .pc_src(pc_src),
    .branch_target(branch_target), .jump_index(jump_index), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .ifid_instr(ifid_instr), .ifid_pc4(ifid_pc4), .ifid_valid(ifid_valid),
    .imm16(imm16), .misalign(misalign)
  );

  always #5 clk = ~clk;
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; flush = 0; pc_src = 2'b00;
    branch_target = '0; jump_index = '0; jr_target = '0;
    step(); step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_imem_addr got=%h exp=%h", imem_addr, 32'h0); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h exp=%h", ifid_instr, 32'h0); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL rst_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", ifid_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign got=%b exp=0", misalign); end
  endtask

  task automatic test_sequential();
    rst = 0;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h4); end
    checks++; if (ifid_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL seq_instr1 got=%h exp=%h", ifid_instr, 32'hA5A5_0000); end
    checks++; if (ifid_pc4 !== 32'h4) begin errors++; $display("FAIL seq_pc4_1 got=%h exp=%h", ifid_pc4, 32'h4); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL seq_valid got=%b exp=1", ifid_valid); end
    step();
    checks++; if (pc !== 32'h8) begin errors++; $display("FAIL seq_pc2 got=%h exp=%h", pc, 32'h8); end
    checks++; if (ifid_instr !== 32'hA5A5_0004) begin errors++; $display("FAIL seq_instr2 got=%h exp=%h", ifid_instr, 32'hA5A5_0004); end
    checks++; if (imm16 !== 16'h0004) begin errors++; $display("FAIL seq_imm16 got=%h exp=%h", imm16, 16'h0004); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h8); end
      checks++; if (ifid_instr !== 32'hA5A5_0004) begin errors++; $display("FAIL stall_instr[%0d] got=%h exp=%h", i, ifid_instr, 32'hA5A5_0004); end
      checks++; if (ifid_pc4 !== 32'h8) begin errors++; $display("FAIL stall_pc4[%0d] got=%h exp=%h", i, ifid_pc4, 32'h8); end
    end
    stall = 0;
    step();
    checks++; if (pc !== 32'hC) begin errors++; $display("FAIL stall_resume_pc got=%h exp=%h", pc, 32'hC); end
    checks++; if (ifid_instr !== 32'hA5A5_0008) begin errors++; $display("FAIL stall_resume_instr got=%h exp=%h", ifid_instr, 32'hA5A5_0008); end
  endtask

  task automatic test_branch();
    step();
    checks++; if (pc !== 32'h10) begin errors++; $display("FAIL br_pre_pc got=%h exp=%h", pc, 32'h10); end
    pc_src = 2'b01; branch_target = 32'h0000_0100;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'h100) begin errors++; $display("FAIL br_pc got=%h exp=%h", pc, 32'h100); end
    checks++; if (ifid_instr !== 32'hA5A5_0010) begin errors++; $display("FAIL br_delay_instr got=%h exp=%h", ifid_instr, 32'hA5A5_0010); end
    checks++; if (ifid_pc4 !== 32'h14) begin errors++; $display("FAIL br_delay_pc4 got=%h exp=%h", ifid_pc4, 32'h14); end
    checks++; if (ifid_valid !== 1'b1) begin errors++; $display("FAIL br_valid got=%b exp=1", ifid_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL br_misalign got=%b exp=0", misalign); end
    // Misaligned branch target: bits[1:0] dropped and flagged.
    pc_src = 2'b01; branch_target = 32'h0000_0201;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'h200) begin errors++; $display("FAIL br_mis_pc got=%h exp=%h", pc, 32'h200); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL br_mis_flag got=%b exp=1", misalign); end
  endtask

  task automatic test_jump();
    pc_src = 2'b11; jr_target = 32'h4000_000C;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'h4000_000C) begin errors++; $display("FAIL jr_setup_pc got=%h exp=%h", pc, 32'h4000_000C); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jr_setup_misalign got=%b exp=0", misalign); end
    step();
    checks++; if (ifid_pc4 !== 32'h4000_0010) begin errors++; $display("FAIL j_pc4 got=%h exp=%h", ifid_pc4, 32'h4000_0010); end
    checks++; if (ifid_instr !== 32'hE5A5_000C) begin errors++; $display("FAIL j_instr got=%h exp=%h", ifid_instr, 32'hE5A5_000C); end
    pc_src = 2'b10; jump_index = 26'h000_0040;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'h4000_0100) begin errors++; $display("FAIL j_pc got=%h exp=%h", pc, 32'h4000_0100); end
    pc_src = 2'b11; jr_target = 32'h0000_2003;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL jr_pc got=%h exp=%h", pc, 32'h2000); end
    checks++; if (misalign !== 1'b1) begin errors++; $display("FAIL jr_misalign got=%b exp=1", misalign); end
    step();
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL jr_misalign_pulse got=%b exp=0", misalign); end
    checks++; if (pc !== 32'h0000_2004) begin errors++; $display("FAIL jr_next_pc got=%h exp=%h", pc, 32'h2004); end
  endtask

  task automatic test_priority();
    flush = 1;
    step();
    flush = 0;
    checks++; if (pc !== 32'h2008) begin errors++; $display("FAIL flush_pc got=%h exp=%h", pc, 32'h2008); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b exp=0", ifid_valid); end
    step();
    stall = 1; flush = 1; pc_src = 2'b01; branch_target = 32'h0000_0300;
    step();
    stall = 0; flush = 0; pc_src = 2'b00;
    checks++; if (pc !== 32'h300) begin errors++; $display("FAIL prio_pc got=%h exp=%h", pc, 32'h300); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL prio_valid got=%b exp=0", ifid_valid); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL prio_instr got=%h exp=%h", ifid_instr, 32'h0); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL prio_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
  endtask

  task automatic test_wrap();
    pc_src = 2'b11; jr_target = 32'hFFFF_FFFC;
    step();
    pc_src = 2'b00;
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
    checks++; if (ifid_instr !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_instr got=%h exp=%h", ifid_instr, 32'h5A5A_FFFC); end
    checks++; if (imm16 !== 16'hFFFC) begin errors++; $display("FAIL wrap_imm16 got=%h exp=%h", imm16, 16'hFFFC); end
  endtask

  task automatic test_reset_mid_stall();
    pc_src = 2'b11; jr_target = 32'h0000_0503;
    step();
    pc_src = 2'b00; stall = 1;
    step();
    rst = 1;
    step();
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL mrst_pc got=%h exp=%h", pc, 32'h0); end
    checks++; if (ifid_instr !== 32'h0) begin errors++; $display("FAIL mrst_instr got=%h exp=%h", ifid_instr, 32'h0); end
    checks++; if (ifid_pc4 !== 32'h0) begin errors++; $display("FAIL mrst_pc4 got=%h exp=%h", ifid_pc4, 32'h0); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b exp=0", ifid_valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL mrst_misalign got=%b exp=0", misalign); end
    rst = 0; stall = 0;
    step();
    checks++; if (pc !== 32'h4) begin errors++; $display("FAIL mrst_resume_pc got=%h exp=%h", pc, 32'h4); end
    checks++; if (ifid_instr !== 32'hA5A5_0000) begin errors++; $display("FAIL mrst_resume_instr got=%h exp=%h", ifid_instr, 32'hA5A5_0000); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_jump();
    test_priority();
    test_wrap();
    test_reset_mid_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the MIPS pipeline, directly upstream of decode.
- Holds the PC and issues the instruction-memory address.
- Selects the next PC from sequential, branch, jump or jump-register sources.
- Registers the fetched word into the IF/ID pipeline register; its low 16 bits (imm16) feed the sign extender in decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  squash IF/ID contents (insert bubble)
- pc_src  in  2  00 sequential, 01 branch, 10 jump, 11 jump-register
- branch_target  in  32  resolved branch address
- jump_index  in  26  instr[25:0] of J/JAL in decode
- jr_target  in  32  register value for JR/JALR
- imem_addr  out  32  instruction memory address; combinational, equals pc
- imem_rdata  in  32  instruction word; combinational read, valid in the same cycle
- pc  out  32  current fetch PC
- ifid_instr  out  32  registered instruction
- ifid_pc4  out  32  registered fetch PC + 4
- ifid_valid  out  1  1 when IF/ID holds a real instruction
- imm16  out  16  ifid_instr[15:0], to sign extender
- misalign  out  1  registered one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
Reset (rst=1 at clock edge, overrides everything):
- pc=RESET_PC, ifid_instr=NOP_WORD, ifid_pc4=0, ifid_valid=0, misalign=0.

Next-PC computation, evaluated each cycle:
- pc_plus4 = pc + 4, modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- Jump target = {ifid_pc4[31:28], jump_index, 2'b00}.
- Branch and JR targets are used with bits[1:0] forced to 00.
- misalign is set for one cycle after a redirect whose raw target had nonzero bits[1:0].

PC update priority (highest first):
1. rst
2. redirect (pc_src != 00): load the selected target. Redirect wins over stall.
3. stall: hold pc.
4. Otherwise: pc <= pc_plus4.

IF/ID update priority (highest first):
1. rst
2. flush: instr=NOP_WORD, pc4=0, valid=0. flush wins over stall.
3. stall: hold all IF/ID fields.
4. Otherwise: instr <= imem_rdata, pc4 <= pc_plus4, valid <= 1.

Redirect rules:
- A redirect does not squash IF/ID by itself; the hazard unit asserts flush when a squash is required.
- With pc_src=01 and flush=0, the sequentially fetched word is captured (branch delay slot).
- pc_src and the target inputs are sampled only at the clock edge; they are don't-care when pc_src=00.
- Simultaneous stall + flush + redirect: pc takes the target, IF/ID becomes a bubble.

Latency:
- One cycle from imem_rdata to ifid_instr.
- imm16 is a combinational slice of the register, so it needs no extra cycle.
- Reset asserted mid-stream takes effect at the next edge; the first fetch after reset release is at RESET_PC.

Test Plan:
- Reset and sequential fetch: rst 2 cycles, then release, imem returns addr^32'hA5A5_0000 → pc 0,4,8,C; ifid_instr=32'hA5A5_0000 with ifid_pc4=4 one cycle after pc=0; ifid_valid rises on the first capture; imm16 matches ifid_instr[15:0].
- Stall hold: stall for 3 cycles at pc=8 → pc stays 8; IF/ID holds the word fetched at 4 with ifid_pc4=8; resume → pc=C.
- Branch with delay slot: pc_src=01, branch_target=32'h0000_0100 at pc=10 → next pc=100; IF/ID holds the word from 10 (no flush); misalign stays 0.
- Jump and JR: ifid_pc4=32'h4000_0010, jump_index=26'h000_0040 → pc=32'h4000_0100. pc_src=11, jr_target=32'h0000_2003 → pc=32'h0000_2000 and misalign=1 for exactly one cycle.
- Priority and corners: stall+flush+redirect together → pc=target, ifid_valid=0, ifid_instr=0. pc=32'hFFFF_FFFC sequential → pc=0. rst asserted mid-stall → all outputs take reset values at the next edge.
